mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch path and the load/store path of the RV32 core.
- Sequences each access over a fixed number of memory wait cycles, returns read data to the requester, and raises a stall towards the PC register while any access is outstanding.
- Sits between the PC/instruction-fetch logic, the load/store datapath and the external memory model.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// stalling the PC while an access is outstanding. Define ARB_RR_EN for round-robin ties.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic [15:0]   conflict_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [15:0]   conflict_q, conflict_d;
  logic          grant_data;

  // owner_q keeps the most recent grant, so it doubles as the round-robin pointer.
  always_comb begin
`ifdef ARB_RR_EN
    grant_data = d_req && (!if_req || !owner_q);
`else
    grant_data = d_req;
`endif
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    conflict_d = conflict_q;
    case (state_q)
      IDLE: begin
        if (if_req && d_req && (conflict_q != '1)) begin
          conflict_d = conflict_q + 16'd1;
        end
        if (if_req || d_req) begin
          owner_d = grant_data;
          addr_d  = grant_data ? d_addr : if_addr;
          we_d    = grant_data && d_we;
          wdata_d = grant_data ? d_wdata : '0;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (owner_q) begin
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      conflict_q <= conflict_d;
    end
  end

  assign mem_req      = (state_q == BUSY);
  assign mem_we       = (state_q == BUSY) && we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign if_done      = (state_q == DONE) && !owner_q;
  assign d_done       = (state_q == DONE) && owner_q;
  assign stall        = (if_req && !if_done) || (d_req && !d_done);
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them. Expected grant order follows ARB_RR_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, d_done, mem_req, mem_we, stall;
  logic [15:0] conflict_cnt;
  logic [31:0] mem [0:255];

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u_dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .conflict_cnt(conflict_cnt)
  );

  assign mem_rdata = mem_req ? mem[mem_addr[9:2]] : '0;
  always @(posedge clk) if (mem_req && mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  // Latency-only instances at the extremes of MEM_LAT; their memory returns ~addr.
  logic        f1_req = 1'b0, f15_req = 1'b0;
  logic [31:0] f1_addr = '0, f15_addr = '0;
  logic [31:0] f1_rdata, f15_rdata, f1_drd, f15_drd, m1_addr, m15_addr, m1_wd, m15_wd;
  logic        f1_done, f15_done, f1_dd, f15_dd, m1_req, m15_req, m1_we, m15_we;
  logic        f1_stall, f15_stall;
  logic [15:0] f1_cc, f15_cc;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rstn(rstn),
    .if_req(f1_req), .if_addr(f1_addr), .if_rdata(f1_rdata), .if_done(f1_done),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(f1_drd), .d_done(f1_dd),
    .mem_req(m1_req), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wd),
    .mem_rdata(m1_req ? ~m1_addr : 32'h0), .stall(f1_stall), .conflict_cnt(f1_cc)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(15)) u_lat15 (
    .clk(clk), .rstn(rstn),
    .if_req(f15_req), .if_addr(f15_addr), .if_rdata(f15_rdata), .if_done(f15_done),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(f15_drd), .d_done(f15_dd),
    .mem_req(m15_req), .mem_we(m15_we), .mem_addr(m15_addr), .mem_wdata(m15_wd),
    .mem_rdata(m15_req ? ~m15_addr : 32'h0), .stall(f15_stall), .conflict_cnt(f15_cc)
  );

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && (if_done || d_done)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got if_done=%b d_done=%b expected none at %0t",
                 if_done, d_done, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_owner", 32'({d_done, if_done}), e.is_data ? 32'd2 : 32'd1);
        check(e.is_data ? "d_rdata" : "if_rdata", e.is_data ? d_rdata : if_rdata, e.rdata);
      end
    end
  end

  task automatic wait_done(input logic want_data, output int lat, output int we_cyc);
    lat    = -1;
    we_cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) we_cyc++;
      if (want_data ? d_done : if_done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done expected %s done", want_data ? "d" : "if");
    end
  endtask

  // One access from an idle arbiter; done must arrive MEM_LAT+1 = 3 negedges later.
  task automatic do_access(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, output int we_cyc);
    int lat;
    @(posedge clk); #1;
    sb.push_back({is_d, exp_rd});
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    wait_done(is_d, lat, we_cyc);
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    check("access_latency", 32'(lat), 32'd3);
  endtask

  task automatic wait_any(output int got);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        got = 1;
        break;
      end
    end
    if (got == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL any_done_timeout: got no done expected a done");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_cyc, got, lat;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'h0010_0093;

    // Reset values
    #12;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_dones", 32'({if_done, d_done}), 32'd0);
    check("rst_conflict", 32'(conflict_cnt), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Single fetch, cycle by cycle
    @(posedge clk); #1;
    sb.push_back({1'b0, 32'h0010_0093});
    if_addr = 32'h10; if_req = 1'b1;
    @(negedge clk);
    check("t1_idle_stall", 32'(stall), 32'd1);
    check("t1_idle_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("t1_busy1_mem_req", 32'(mem_req), 32'd1);
    check("t1_busy1_mem_addr", mem_addr, 32'h10);
    check("t1_busy1_mem_we", 32'(mem_we), 32'd0);
    check("t1_busy1_stall", 32'(stall), 32'd1);
    @(negedge clk);
    check("t1_busy2_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    check("t1_done_mem_req", 32'(mem_req), 32'd0);
    check("t1_done_if_done", 32'(if_done), 32'd1);
    check("t1_done_stall", 32'(stall), 32'd0);
    if_req = 1'b0;

    // Store leaves d_rdata at its reset value; load returns the stored word
    do_access(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, we_cyc);
    check("store_we_cycles", 32'(we_cyc), 32'd2);
    check("nonowner_if_rdata", if_rdata, 32'h0010_0093);
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, we_cyc);
    check("load_we_cycles", 32'(we_cyc), 32'd0);

    // Reset in the second BUSY cycle aborts without a done pulse
    @(posedge clk); #1;
    if_addr = 32'h10; if_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #2 rstn = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'd0);
    check("abort_if_rdata", if_rdata, 32'd0);
    check("abort_d_rdata", d_rdata, 32'd0);
    check("abort_dones", 32'({if_done, d_done}), 32'd0);
    if_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 32'h0010_0093, we_cyc);

    // Single tie: data first in both modes (last owner is fetch)
    @(posedge clk); #1;
    sb.push_back({1'b1, 32'hDEAD_BEEF});
    sb.push_back({1'b0, 32'h0010_0093});
    d_we = 1'b0; d_addr = 32'h100; d_req = 1'b1;
    if_addr = 32'h10; if_req = 1'b1;
    wait_done(1'b1, lat, we_cyc);
    d_req = 1'b0;
    wait_done(1'b0, lat, we_cyc);
    if_req = 1'b0;
    check("tie_conflict_cnt", 32'(conflict_cnt), 32'd1);

    // Both held: three contested grants, then d_req drops and fetch finishes
    @(posedge clk); #1;
`ifdef ARB_RR_EN
    sb.push_back({1'b1, 32'hDEAD_BEEF});
    sb.push_back({1'b0, 32'h0010_0093});
    sb.push_back({1'b1, 32'hDEAD_BEEF});
    sb.push_back({1'b0, 32'h0010_0093});
`else
    sb.push_back({1'b1, 32'hDEAD_BEEF});
    sb.push_back({1'b1, 32'hDEAD_BEEF});
    sb.push_back({1'b1, 32'hDEAD_BEEF});
    sb.push_back({1'b0, 32'h0010_0093});
`endif
    d_req = 1'b1; if_req = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      wait_any(got);
      if (n == 3) d_req = 1'b0;
      if (n == 4) if_req = 1'b0;
    end
    check("cont_conflict_cnt", 32'(conflict_cnt), 32'd4);

    // MEM_LAT extremes: done at request edge + MEM_LAT + 1
    @(posedge clk); #1;
    f1_addr = 32'h40; f1_req = 1'b1;
    lat = 99;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (f1_done) begin
        lat = i;
        check("lat1_rdata", f1_rdata, 32'hFFFF_FFBF);
        break;
      end
    end
    f1_req = 1'b0;
    check("lat1_latency", 32'(lat), 32'd2);

    @(posedge clk); #1;
    f15_addr = 32'h80; f15_req = 1'b1;
    lat = 99;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (f15_done) begin
        lat = i;
        check("lat15_rdata", f15_rdata, 32'hFFFF_FF7F);
        break;
      end
    end
    f15_req = 1'b0;
    check("lat15_latency", 32'(lat), 32'd16);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
